// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants and types for the VGA text layer
// Glyph geometry, pipeline latency and RGB222 colour constants.
package vga_text_pkg;

  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int LATENCY = 4;

  typedef logic [5:0] rgb222_t;

  localparam rgb222_t COLOR_FG_DEFAULT = 6'h3F;
  localparam rgb222_t COLOR_BG_DEFAULT = 6'h01;
  localparam rgb222_t COLOR_BLACK      = 6'h00;

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register chain with a per-instance reset value
// Keeps side-band signals aligned with the memory fetch pipeline.
module vga_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_text_layer.sv
// rtl/vga_text_layer.sv - text-mode pixel stage: (x, y, syncs) to RGB222 via char RAM and font ROM
// Optional blinking underline cursor when TEXT_CURSOR_EN is defined.
module vga_text_layer
  import vga_text_pkg::*;
#(
  parameter int      COLS         = 80,
  parameter int      ROWS         = 30,
  parameter int      H_ACTIVE     = 640,
  parameter int      V_ACTIVE     = 480,
  parameter rgb222_t FG_COLOR     = COLOR_FG_DEFAULT,
  parameter rgb222_t BG_COLOR     = COLOR_BG_DEFAULT,
`ifdef TEXT_CURSOR_EN
  parameter int      BLINK_FRAMES = 30,
`endif
  parameter int      AW           = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [AW-1:0] char_addr,
  input  logic [7:0]    char_data,
  output logic [10:0]   glyph_addr,
  input  logic [7:0]    glyph_data,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]    cursor_col,
  input  logic [4:0]    cursor_row,
`endif
  output logic [5:0]    rgb,
  output logic          hs_out,
  output logic          vs_out
);

  localparam int PXW = $clog2(CHAR_W);
  localparam int GRW = $clog2(CHAR_H);

  logic            active_in;
  logic [9-PXW:0]  col_idx;
  logic [9-GRW:0]  row_idx;
  logic            active_d3;
  logic [PXW-1:0]  px_d3;
  logic [GRW-1:0]  grow_d2;
  logic            glyph_bit;
  logic            pix_on;

  logic [AW-1:0]   char_addr_q, char_addr_d;
  logic            inv_q, inv_d;
  rgb222_t         rgb_q, rgb_d;

  assign active_in = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
  assign col_idx   = x[9:PXW];
  assign row_idx   = y[9:GRW];

  vga_delay_line #(.WIDTH(2), .DEPTH(LATENCY), .RESET_VALUE(2'b11)) u_sync_dl (
    .clk(clk), .rst_n(rst_n), .din({hs_in, vs_in}), .dout({hs_out, vs_out})
  );

  vga_delay_line #(.WIDTH(1 + PXW), .DEPTH(LATENCY - 1), .RESET_VALUE('0)) u_pix_dl (
    .clk(clk), .rst_n(rst_n), .din({active_in, x[PXW-1:0]}), .dout({active_d3, px_d3})
  );

  vga_delay_line #(.WIDTH(GRW), .DEPTH(2), .RESET_VALUE('0)) u_grow_dl (
    .clk(clk), .rst_n(rst_n), .din(y[GRW-1:0]), .dout(grow_d2)
  );

  assign glyph_addr = {char_data[6:0], grow_d2};
  assign glyph_bit  = glyph_data[PXW'(CHAR_W - 1) - px_d3];

`ifdef TEXT_CURSOR_EN
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic           hit_in, hit_d3;
  logic           vs_prev_q, vs_prev_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           phase_q, phase_d;

  // Underline: last two glyph rows of the cursor cell; off-screen cursors never match.
  assign hit_in = active_in
               && (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS)
               && (int'(col_idx) == int'(cursor_col))
               && (int'(row_idx) == int'(cursor_row))
               && (y[GRW-1:0] >= GRW'(CHAR_H - 2));

  vga_delay_line #(.WIDTH(1), .DEPTH(LATENCY - 1), .RESET_VALUE(1'b0)) u_hit_dl (
    .clk(clk), .rst_n(rst_n), .din(hit_in), .dout(hit_d3)
  );

  always_comb begin
    vs_prev_d   = vs_in;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (vs_prev_q && !vs_in) begin
      if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign pix_on = (hit_d3 && phase_q) ? 1'b1 : (glyph_bit ^ inv_q);
`else
  assign pix_on = glyph_bit ^ inv_q;
`endif

  always_comb begin
    char_addr_d = active_in ? AW'(AW'(row_idx) * AW'(COLS) + AW'(col_idx)) : '0;
    inv_d       = char_data[7];
    rgb_d       = active_d3 ? (pix_on ? FG_COLOR : BG_COLOR) : COLOR_BLACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_addr_q <= '0;
      inv_q       <= 1'b0;
      rgb_q       <= COLOR_BLACK;
`ifdef TEXT_CURSOR_EN
      vs_prev_q   <= 1'b1;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      char_addr_q <= char_addr_d;
      inv_q       <= inv_d;
      rgb_q       <= rgb_d;
`ifdef TEXT_CURSOR_EN
      vs_prev_q   <= vs_prev_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

  assign char_addr = char_addr_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_vga_text_layer.sv
// tb/tb_vga_text_layer.sv - scoreboard bench for vga_text_layer with sync RAM/ROM models
// Cursor scenarios are exercised when TEXT_CURSOR_EN is defined.
module tb_vga_text_layer;
  import vga_text_pkg::*;

  localparam int LAT   = LATENCY;
  localparam int BLINK = 2;
`ifdef TEXT_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        hs_in = 1'b1, vs_in = 1'b1;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [10:0] glyph_addr;
  logic [7:0]  glyph_data;
  logic [6:0]  cursor_col = 7'd3;
  logic [4:0]  cursor_row = 5'd2;
  logic [5:0]  rgb;
  logic        hs_out, vs_out;

  logic [7:0] char_mem [0:2399];
  logic [7:0] font     [0:2047];

  exp_t exp_q [$];
  int   addr_q [$];
  int   checks = 0;
  int   errors = 0;
  int   falls = 0;
  logic prev_vs = 1'b1;

  always #5 clk = ~clk;

`ifdef TEXT_CURSOR_EN
  vga_text_layer #(.BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .hs_in(hs_in), .vs_in(vs_in),
    .char_addr(char_addr), .char_data(char_data),
    .glyph_addr(glyph_addr), .glyph_data(glyph_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out)
  );
`else
  vga_text_layer dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .hs_in(hs_in), .vs_in(vs_in),
    .char_addr(char_addr), .char_data(char_data),
    .glyph_addr(glyph_addr), .glyph_data(glyph_data),
    .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out)
  );
`endif

  always @(posedge clk) begin
    char_data  <= char_mem[char_addr];
    glyph_data <= font[glyph_addr];
  end

  function automatic int ref_addr(int px, int py);
    if (px < 640 && py < 480) return (py / 16) * 80 + px / 8;
    return 0;
  endfunction

  function automatic exp_t ref_pixel(int px, int py, logic h, logic v, bit ph);
    exp_t       e;
    logic [7:0] c;
    logic [7:0] g;
    bit         b;
    e.hs  = h;
    e.vs  = v;
    e.rgb = 6'h00;
    if (px < 640 && py < 480) begin
      c = char_mem[ref_addr(px, py)];
      g = font[int'(c[6:0]) * 16 + py % 16];
      b = g[7 - px % 8] ^ c[7];
      if (CUR_EN && ph && cursor_col < 80 && cursor_row < 30 &&
          px / 8 == int'(cursor_col) && py / 16 == int'(cursor_row) && py % 16 >= 14)
        b = 1'b1;
      e.rgb = b ? 6'h3F : 6'h01;
    end
    return e;
  endfunction

  task automatic drive(input int px, input int py, input logic h, input logic v, input logic r);
    exp_t blank;
    blank.rgb = 6'h00;
    blank.hs  = 1'b1;
    blank.vs  = 1'b1;
    @(posedge clk);
    #1;
    x = 10'(px); y = 10'(py); hs_in = h; vs_in = v;
    if (rst_n && !r) begin
      rst_n = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) exp_q[i] = blank;
      for (int i = 0; i < addr_q.size(); i++) addr_q[i] = 0;
    end
    rst_n = r;
    if (!r) begin
      falls   = 0;
      prev_vs = 1'b1;
      exp_q.push_back(blank);
      addr_q.push_back(0);
    end else begin
      if (prev_vs && !v) falls++;
      prev_vs = v;
      exp_q.push_back(ref_pixel(px, py, h, v, ((falls / BLINK) % 2) == 1));
      addr_q.push_back(ref_addr(px, py));
    end
  endtask

  task automatic mini_frame();
    for (int ly = 44; ly < 48; ly++)
      for (int lx = 16; lx < 40; lx++) drive(lx, ly, 1'b1, 1'b1, 1'b1);
    repeat (4) drive(700, 500, 1'b1, 1'b1, 1'b1);
    repeat (3) drive(700, 500, 1'b1, 1'b0, 1'b1);
    repeat (4) drive(700, 500, 1'b1, 1'b1, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (addr_q.size() > 1) begin
      a = addr_q.pop_front();
      checks++;
      if (char_addr !== 12'(a)) begin
        errors++;
        $display("FAIL char_addr got %0d want %0d", char_addr, a);
      end
    end
    if (exp_q.size() > LAT) begin
      e = exp_q.pop_front();
      checks++;
      if (rgb !== e.rgb) begin
        errors++;
        $display("FAIL rgb got %h want %h", rgb, e.rgb);
      end
      checks++;
      if (hs_out !== e.hs) begin
        errors++;
        $display("FAIL hs_out got %b want %b", hs_out, e.hs);
      end
      checks++;
      if (vs_out !== e.vs) begin
        errors++;
        $display("FAIL vs_out got %b want %b", vs_out, e.vs);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2400; i++) char_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    char_mem[0] = 8'h41;
    char_mem[1] = 8'hC1;
    font[16'h41 * 16] = 8'h81;

    repeat (6) drive(700, 500, 1'b1, 1'b1, 1'b0);

    if (CUR_EN) begin
      repeat (6) mini_frame();
      cursor_col = 7'd80;
      repeat (4) mini_frame();
    end
    cursor_col = 7'd80;

    for (int i = 0; i < 16; i++) drive(i, 0, 1'b1, 1'b1, 1'b1);
    drive(640, 0, 1'b1, 1'b1, 1'b1);
    drive(639, 479, 1'b1, 1'b1, 1'b1);
    drive(8, 16, 1'b1, 1'b1, 1'b1);
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    repeat (3) drive(100, 100, 1'b0, 1'b1, 1'b1);
    repeat (2) drive(100, 100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(i, 0, 1'b0, 1'b0, 1'b1);

    drive(5, 0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (rgb !== 6'h00 || hs_out !== 1'b1 || vs_out !== 1'b1 || char_addr !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got rgb=%h hs=%b vs=%b addr=%0d want 00 1 1 0",
               rgb, hs_out, vs_out, char_addr);
    end
    repeat (3) drive(0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(i, 0, 1'b0, 1'b1, 1'b1);

    repeat (3000)
      drive($urandom_range(0, 1023), $urandom_range(0, 1023),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) != 0), 1'b1);
    repeat (LAT + 2) drive(700, 500, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
